// File: rtl/lsu_pkg.sv
`default_nettype none
// lsu_pkg: shared types and funct3 decode for the data-memory load/store unit.
// Rev 1.0
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    HOLD = 2'd2
  } lsu_state_t;

  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic [1:0] off;
    logic       misalign;
  } lsu_pend_t;

  // Unknown encodings (including unsigned stores) are folded into the misaligned path.
  function automatic logic is_misaligned(input logic we, input logic [2:0] f3,
                                         input logic [1:0] off);
    logic mis;
    case (f3)
      F3_LB:   mis = 1'b0;
      F3_LH:   mis = off[0];
      F3_LW:   mis = (off != 2'b00);
      F3_LBU:  mis = we;
      F3_LHU:  mis = we | off[0];
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// load_align: selects the addressed lane of SRAM read data and sign/zero-extends it.
// Rev 1.0
module load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] sram_do,
  input  lsu_pend_t       pend,
  output logic [XLEN-1:0] rdata
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = sram_do[{pend.off, 3'b000} +: 8];
  assign lane_h = sram_do[{pend.off[1], 4'b0000} +: 16];

  always_comb begin
    rdata = '0;
    if (!pend.we && !pend.misalign) begin
      case (pend.funct3)
        F3_LB:   rdata = {{(XLEN-8){lane_b[7]}}, lane_b};
        F3_LH:   rdata = {{(XLEN-16){lane_h[15]}}, lane_h};
        F3_LW:   rdata = sram_do;
        F3_LBU:  rdata = {{(XLEN-8){1'b0}}, lane_b};
        F3_LHU:  rdata = {{(XLEN-16){1'b0}}, lane_h};
        default: rdata = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_lsu.sv
`default_nettype none
// data_mem_lsu: RV32I load/store unit driving a 1-cycle-latency data SRAM with response hold.
// Rev 1.0
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_misalign,
  output logic              sram_ceb,
  output logic              sram_web,
  output logic [XLEN-1:0]   sram_bweb,
  output logic [ADDR_W-1:0] sram_a,
  output logic [XLEN-1:0]   sram_di,
  input  logic [XLEN-1:0]   sram_do
);

  lsu_state_t      state;
  lsu_pend_t       pend;
  lsu_pend_t       pend_next;
  logic [XLEN-1:0] hold_rdata;
  logic            hold_misalign;
  logic [XLEN-1:0] align_rdata;
  logic [XLEN-1:0] lane_mask;
  logic            req_mis;
  logic            accept;
  logic            issue;
  logic            unused_addr_hi;

  assign unused_addr_hi = ^req_addr[XLEN-1:ADDR_W+2];

  assign req_mis   = is_misaligned(req_we, req_funct3, req_addr[1:0]);
  assign req_ready = !rst && ((state == IDLE) || resp_ready);
  assign accept    = req_valid && req_ready;
  assign issue     = accept && !req_mis;

  assign pend_next = '{we: req_we, funct3: req_funct3, off: req_addr[1:0], misalign: req_mis};

  assign sram_a = req_addr[ADDR_W+1:2];

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   sram_di = {4{req_wdata[7:0]}};
      2'b01:   sram_di = {2{req_wdata[15:0]}};
      default: sram_di = req_wdata;
    endcase
  end

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   lane_mask = {{(XLEN-8){1'b0}}, 8'hFF} << {req_addr[1:0], 3'b000};
      2'b01:   lane_mask = {{(XLEN-16){1'b0}}, 16'hFFFF} << {req_addr[1], 4'b0000};
      default: lane_mask = '1;
    endcase
  end

  always_comb begin
    sram_ceb  = 1'b1;
    sram_web  = 1'b1;
    sram_bweb = '1;
    if (issue) begin
      sram_ceb = 1'b0;
      if (req_we) begin
        sram_web  = 1'b0;
        sram_bweb = ~lane_mask;
      end
    end
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .sram_do (sram_do),
    .pend    (pend),
    .rdata   (align_rdata)
  );

  // A new request is only accepted when the previous response is consumed, so accept always lands in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pend          <= '0;
      hold_rdata    <= '0;
      hold_misalign <= 1'b0;
    end else begin
      if (accept) begin
        pend <= pend_next;
      end
      case (state)
        IDLE: if (accept) state <= RESP;
        RESP: begin
          if (accept) begin
            state <= RESP;
          end else if (resp_ready) begin
            state <= IDLE;
          end else begin
            state         <= HOLD;
            hold_rdata    <= align_rdata;
            hold_misalign <= pend.misalign;
          end
        end
        HOLD: begin
          if (accept) begin
            state <= RESP;
          end else if (resp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign resp_valid = (state != IDLE);

  always_comb begin
    case (state)
      RESP: begin
        resp_rdata    = align_rdata;
        resp_misalign = pend.misalign;
      end
      HOLD: begin
        resp_rdata    = hold_rdata;
        resp_misalign = hold_misalign;
      end
      default: begin
        resp_rdata    = '0;
        resp_misalign = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_lsu.sv
`default_nettype none
// tb_data_mem_lsu: directed bench with a behavioural SRAM and an expected-response scoreboard.
// Rev 1.0
module tb_data_mem_lsu;

  localparam int ADDR_W = 14;
  localparam int XLEN   = 32;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_misalign;
  logic              sram_ceb;
  logic              sram_web;
  logic [XLEN-1:0]   sram_bweb;
  logic [ADDR_W-1:0] sram_a;
  logic [XLEN-1:0]   sram_di;
  logic [XLEN-1:0]   sram_do;

  logic [XLEN-1:0]   mem [0:(1<<ADDR_W)-1];
  logic [XLEN-1:0]   sram_q;
  logic              force_zero;

  typedef struct packed {
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   passed;

  data_mem_lsu #(.ADDR_W(ADDR_W), .XLEN(XLEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_misalign (resp_misalign),
    .sram_ceb      (sram_ceb),
    .sram_web      (sram_web),
    .sram_bweb     (sram_bweb),
    .sram_a        (sram_a),
    .sram_di       (sram_di),
    .sram_do       (sram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!sram_ceb) begin
      if (!sram_web) mem[sram_a] <= (mem[sram_a] & sram_bweb) | (sram_di & ~sram_bweb);
      else           sram_q      <= mem[sram_a];
    end
  end
  assign sram_do = force_zero ? '0 : sram_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
  endtask

  task automatic push(input logic [31:0] rdata, input logic mis);
    exp_t e;
    e.rdata = rdata;
    e.mis   = mis;
    sb.push_back(e);
  endtask

  task automatic resp_check(input string tag);
    exp_t e;
    chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, resp_rdata, e.rdata);
      chk({tag, "_mis"}, 32'(resp_misalign), 32'(e.mis));
    end
  endtask

  initial begin
    total      = 0;
    passed     = 0;
    force_zero = 1'b0;
    sram_q     = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    rst        = 1'b1;
    resp_ready = 1'b1;
    drive(1'b0, 3'b010, 32'h10, 32'h0);

    // Reset: no SRAM access even with a request pending
    repeat (2) next_cycle();
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_mis", 32'(resp_misalign), 32'd0);
    chk("rst_ceb", 32'(sram_ceb), 32'd1);
    chk("rst_web", 32'(sram_web), 32'd1);
    chk("rst_bweb", sram_bweb, 32'hFFFF_FFFF);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    next_cycle();
    rst = 1'b0;

    // SW 0x10
    drive(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    push(32'h0, 1'b0);
    @(negedge clk);
    chk("sw_ceb", 32'(sram_ceb), 32'd0);
    chk("sw_web", 32'(sram_web), 32'd0);
    chk("sw_bweb", sram_bweb, 32'h0);
    chk("sw_a", 32'(sram_a), 32'd4);
    chk("sw_di", sram_di, 32'hDEAD_BEEF);
    chk("sw_req_ready", 32'(req_ready), 32'd1);
    next_cycle();

    // Byte/half loads back-to-back
    drive(1'b0, 3'b000, 32'h13, 32'h0);
    push(32'hFFFF_FFDE, 1'b0);
    @(negedge clk);
    resp_check("sw");
    chk("lb_ceb", 32'(sram_ceb), 32'd0);
    chk("lb_web", 32'(sram_web), 32'd1);
    chk("lb_bweb", sram_bweb, 32'hFFFF_FFFF);
    next_cycle();
    drive(1'b0, 3'b100, 32'h12, 32'h0);
    push(32'h0000_00AD, 1'b0);
    @(negedge clk);
    resp_check("lb");
    next_cycle();
    drive(1'b0, 3'b101, 32'h10, 32'h0);
    push(32'h0000_BEEF, 1'b0);
    @(negedge clk);
    resp_check("lbu");
    next_cycle();

    // SB into lane 1, then read the merged word
    drive(1'b1, 3'b000, 32'h11, 32'h0000_005A);
    push(32'h0, 1'b0);
    @(negedge clk);
    resp_check("lhu");
    chk("sb_bweb", sram_bweb, 32'hFFFF_00FF);
    chk("sb_di", sram_di, 32'h5A5A_5A5A);
    chk("sb_web", 32'(sram_web), 32'd0);
    next_cycle();
    drive(1'b0, 3'b010, 32'h10, 32'h0);
    push(32'hDEAD_5AEF, 1'b0);
    @(negedge clk);
    resp_check("sb");
    next_cycle();
    req_valid = 1'b0;
    @(negedge clk);
    resp_check("lw");
    next_cycle();
    @(negedge clk);
    chk("idle_valid", 32'(resp_valid), 32'd0);
    chk("idle_rdata", resp_rdata, 32'h0);

    // Stall: response must hold while sram_do is corrupted; a pending SW waits
    drive(1'b0, 3'b010, 32'h10, 32'h0);
    push(32'hDEAD_5AEF, 1'b0);
    next_cycle();
    resp_ready = 1'b0;
    drive(1'b1, 3'b010, 32'h14, 32'h1234_5678);
    @(negedge clk);
    chk("stall_resp_rdata", resp_rdata, 32'hDEAD_5AEF);
    chk("stall_req_ready", 32'(req_ready), 32'd0);
    chk("stall_ceb", 32'(sram_ceb), 32'd1);
    next_cycle();
    force_zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_rdata", resp_rdata, 32'hDEAD_5AEF);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_ceb", 32'(sram_ceb), 32'd1);
      next_cycle();
    end
    resp_ready = 1'b1;
    push(32'h0, 1'b0);
    @(negedge clk);
    chk("release_req_ready", 32'(req_ready), 32'd1);
    chk("release_ceb", 32'(sram_ceb), 32'd0);
    resp_check("hold");
    next_cycle();
    force_zero = 1'b0;

    // Misaligned and unknown encodings: no access, misalign flagged
    drive(1'b0, 3'b010, 32'h12, 32'h0);
    push(32'h0, 1'b1);
    @(negedge clk);
    resp_check("sw14");
    chk("lw_mis_ceb", 32'(sram_ceb), 32'd1);
    chk("lw_mis_web", 32'(sram_web), 32'd1);
    next_cycle();
    drive(1'b0, 3'b001, 32'h12, 32'h0);
    push(32'hFFFF_DEAD, 1'b0);
    @(negedge clk);
    resp_check("lw_mis");
    next_cycle();
    drive(1'b1, 3'b001, 32'h13, 32'hFFFF_FFFF);
    push(32'h0, 1'b1);
    @(negedge clk);
    resp_check("lh");
    chk("sh_mis_ceb", 32'(sram_ceb), 32'd1);
    chk("sh_mis_bweb", sram_bweb, 32'hFFFF_FFFF);
    next_cycle();
    drive(1'b0, 3'b011, 32'h10, 32'h0);
    push(32'h0, 1'b1);
    @(negedge clk);
    resp_check("sh_mis");
    chk("f3_unk_ceb", 32'(sram_ceb), 32'd1);
    next_cycle();

    // Back-to-back loads, reset during the second response with a store pending
    drive(1'b0, 3'b010, 32'h10, 32'h0);
    push(32'hDEAD_5AEF, 1'b0);
    @(negedge clk);
    resp_check("f3_unk");
    next_cycle();
    drive(1'b0, 3'b010, 32'h14, 32'h0);
    push(32'h1234_5678, 1'b0);
    @(negedge clk);
    resp_check("b2b_1");
    next_cycle();
    rst = 1'b1;
    drive(1'b1, 3'b010, 32'h10, 32'h0);
    @(negedge clk);
    resp_check("b2b_2");
    chk("rst_mid_ceb", 32'(sram_ceb), 32'd1);
    chk("rst_mid_req_ready", 32'(req_ready), 32'd0);
    next_cycle();
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(resp_valid), 32'd0);
    chk("post_rst_rdata", resp_rdata, 32'h0);
    next_cycle();
    drive(1'b0, 3'b010, 32'h10, 32'h0);
    push(32'hDEAD_5AEF, 1'b0);
    next_cycle();
    req_valid = 1'b0;
    @(negedge clk);
    resp_check("no_write_in_rst");
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
